codificador_prioridade_n: RTL and testbench



---
 rtl/codificador_prioridade_n.sv | 119 +++++++++++
 tb/tb_codificador_prioridade_n.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_prioridade_n.sv
// Registered N-channel request encoder: edge-captures req_in into pending
// bits and hands out one index at a time over out_valid/out_ready.
// Ports: clk, rst_n (async, active-low), req_in[N], out_idx[W],
//   out_valid, out_ready, pending[N], lost (one-cycle pulse).
// Option: define CODIF_RR_EN for round-robin selection, else lowest wins.
module codificador_prioridade_n #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         lost
);

  typedef enum logic {
    IDLE,
    PRESENT
  } st_e;

  st_e          st_q;
  logic [N-1:0] req_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] pend_d;
  logic [W-1:0] idx_q;
  logic         lost_q;
  logic         lost_d;

  logic         hs;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] sel_vec;
  logic [W-1:0] sel_idx;
  logic         sel_any;

`ifdef CODIF_RR_EN
  logic [W-1:0] ptr_q;
  logic [W-1:0] sel_base;
  logic         found;
  int           j;
`endif

  always_comb begin
    hs   = (st_q == PRESENT) && out_ready;
    rise = req_in & ~req_q;
    clr  = '0;
    if (hs) clr[idx_q] = 1'b1;
    pend_d  = (pend_q & ~clr) | rise;
    lost_d  = |(rise & pend_q & ~clr);
    // On a handshake the granted bit is already gone from the search.
    sel_vec = hs ? (pend_q & ~clr) : pend_q;
    sel_any = |sel_vec;
    sel_idx = '0;
`ifdef CODIF_RR_EN
    // Search starts just past the last grant; the grant now being
    // accepted counts as the last one.
    sel_base = hs ? idx_q : ptr_q;
    found    = 1'b0;
    j        = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(sel_base) + k;
      if (j >= N) j = j - N;
      if (!found && sel_vec[j]) begin
        sel_idx = W'(j);
        found   = 1'b1;
      end
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_vec[i]) sel_idx = W'(i);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      req_q  <= '0;
      pend_q <= '0;
      idx_q  <= '0;
      lost_q <= 1'b0;
`ifdef CODIF_RR_EN
      ptr_q  <= '0;
`endif
    end else begin
      req_q  <= req_in;
      pend_q <= pend_d;
      lost_q <= lost_d;
`ifdef CODIF_RR_EN
      if (hs) ptr_q <= idx_q;
`endif
      unique case (st_q)
        IDLE: begin
          if (sel_any) begin
            idx_q <= sel_idx;
            st_q  <= PRESENT;
          end
        end
        PRESENT: begin
          if (hs) begin
            if (sel_any) idx_q <= sel_idx;
            else         st_q  <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign out_idx   = idx_q;
  assign out_valid = (st_q == PRESENT);
  assign pending   = pend_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_codificador_prioridade_n.sv
// Scoreboard bench for codificador_prioridade_n, N=8 and N=5 instances.
// Reference model works on sets of pending channels per cycle.
module tb_codificador_prioridade_n;

  logic       clk;
  logic       rst_n;
  logic [7:0] req8;
  logic       rdy8;
  logic [2:0] idx8;
  logic       v8;
  logic [7:0] pend8;
  logic       lost8;
  logic [4:0] req5;
  logic       rdy5;
  logic [2:0] idx5;
  logic       v5;
  logic [4:0] pend5;
  logic       lost5;

  int total = 0;
  int bad   = 0;
  int q8[$];
  int q5[$];

  typedef struct {
    bit       v;
    int       idx;
    bit [7:0] p;
    bit [7:0] rd;
    bit       l;
    int       last;
  } mst_t;

  mst_t m8;
  mst_t m5;

  codificador_prioridade_n #(.N(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req8),
    .out_idx   (idx8),
    .out_valid (v8),
    .out_ready (rdy8),
    .pending   (pend8),
    .lost      (lost8)
  );

  codificador_prioridade_n #(.N(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req5),
    .out_idx   (idx5),
    .out_valid (v5),
    .out_ready (rdy5),
    .pending   (pend5),
    .lost      (lost5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mst_t mreset();
    mst_t s;
    s.v = 0; s.idx = 0; s.p = 0; s.rd = 0; s.l = 0; s.last = 0;
    return s;
  endfunction

  // Next channel to serve out of set v, given the last served channel.
  function automatic int pick(bit [7:0] v, int n, int last);
`ifdef CODIF_RR_EN
    for (int k = 1; k <= n; k++)
      if (v[(last + k) % n]) return (last + k) % n;
`else
    for (int c = 0; c < n; c++)
      if (v[c]) return c;
`endif
    return 0;
  endfunction

  function automatic mst_t step(mst_t s, int n, bit [7:0] req, bit rdy);
    mst_t r = s;
    bit took = s.v && rdy;
    bit [7:0] left;
    r.l = 0;
    for (int c = 0; c < n; c++) begin
      bit edge_c = req[c] && !s.rd[c];
      bit gone_c = took && (s.idx == c);
      if (edge_c && s.p[c] && !gone_c) r.l = 1;
      r.p[c] = edge_c || (s.p[c] && !gone_c);
    end
    r.rd = req;
    left = s.p;
    if (took) left[s.idx] = 0;
    if (took) r.last = s.idx;
    if (!s.v || took) begin
      r.v = (left != 0);
      if (left != 0) r.idx = pick(left, n, took ? s.idx : s.last);
    end
    return r;
  endfunction

  task automatic compare_all();
    chk("v8", v8, m8.v);
    if (m8.v) chk("idx8", idx8, m8.idx);
    chk("pend8", pend8, m8.p);
    chk("lost8", lost8, m8.l);
    chk("v5", v5, m5.v);
    if (m5.v) begin
      chk("idx5", idx5, m5.idx);
      chk("idx5_range", int'(idx5 <= 3'd4), 1);
    end
    chk("pend5", pend5, m5.p[4:0]);
    chk("lost5", lost5, m5.l);
  endtask

  task automatic cyc(input logic [7:0] r8, input logic a8,
                     input logic [4:0] r5, input logic a5);
    @(posedge clk);
    #2;
    compare_all();
    req8 = r8; rdy8 = a8; req5 = r5; rdy5 = a5;
    if (m8.v && a8) q8.push_back(m8.idx);
    if (m5.v && a5) q5.push_back(m5.idx);
    m8 = step(m8, 8, r8, a8);
    m5 = step(m5, 5, {3'b000, r5}, a5);
  endtask

  task automatic do_reset(input logic [7:0] r8, input logic [4:0] r5);
    @(posedge clk);
    #2;
    compare_all();
    rst_n = 1'b0;
    req8 = r8; req5 = r5; rdy8 = 1'b0; rdy5 = 1'b0;
    #1;
    chk("rst_v8", v8, 0);
    chk("rst_idx8", idx8, 0);
    chk("rst_pend8", pend8, 0);
    chk("rst_lost8", lost8, 0);
    chk("rst_v5", v5, 0);
    chk("rst_idx5", idx5, 0);
    chk("rst_pend5", pend5, 0);
    chk("rst_lost5", lost5, 0);
    m8 = mreset();
    m5 = mreset();
    q8.delete();
    q5.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    m8 = step(m8, 8, r8, 1'b0);
    m5 = step(m5, 5, {3'b000, r5}, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && v8 && rdy8) begin
      if (q8.size() == 0) chk("sb8_spurious", v8, 0);
      else chk("sb8_idx", idx8, q8.pop_front());
    end
    if (rst_n && v5 && rdy5) begin
      if (q5.size() == 0) chk("sb5_spurious", v5, 0);
      else chk("sb5_idx", idx5, q5.pop_front());
    end
  end

  int seq[3];

  initial begin
`ifdef CODIF_RR_EN
    seq = '{7, 1, 4};
`else
    seq = '{1, 4, 7};
`endif
    req8 = 0; rdy8 = 0; req5 = 0; rdy5 = 0;
    m8 = mreset();
    m5 = mreset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    do_reset(8'h00, 5'h00);

    // single pulse on channel 5
    cyc(8'h20, 1, 0, 1);
    cyc(8'h00, 1, 0, 1);
    chk("p5_pend", pend8[5], 1);
    chk("p5_early", v8, 0);
    cyc(8'h00, 1, 0, 1);
    chk("p5_valid", v8, 1);
    chk("p5_idx", idx8, 5);
    cyc(8'h00, 1, 0, 1);
    chk("p5_once", v8, 0);
    chk("p5_clear", pend8, 0);

    // grant channel 4 so the round-robin pointer sits at 4
    cyc(8'h10, 1, 0, 1);
    cyc(8'h00, 1, 0, 1);
    cyc(8'h00, 1, 0, 1);
    chk("g4_idx", idx8, 4);
    cyc(8'h00, 1, 0, 1);

    // three simultaneous requests, back-to-back delivery
    cyc(8'h92, 1, 0, 1);
    cyc(8'h00, 1, 0, 1);
    chk("burst_pend", pend8, 8'h92);
    for (int k = 0; k < 3; k++) begin
      cyc(8'h00, 1, 0, 1);
      chk("burst_v", v8, 1);
      chk("burst_idx", idx8, seq[k]);
    end
    cyc(8'h00, 1, 0, 1);
    chk("burst_end", v8, 0);

    // repeat edge on a held channel while the consumer stalls
    cyc(8'h04, 0, 0, 0);
    cyc(8'h00, 0, 0, 0);
    cyc(8'h00, 0, 0, 0);
    chk("st_idx", idx8, 2);
    cyc(8'h04, 0, 0, 0);
    chk("st_nolost", lost8, 0);
    cyc(8'h00, 0, 0, 0);
    chk("st_lost", lost8, 1);
    chk("st_hold", idx8, 2);
    cyc(8'h00, 0, 0, 0);
    chk("st_lost1", lost8, 0);
    cyc(8'h00, 1, 0, 0);
    chk("st_still", idx8, 2);
    cyc(8'h00, 1, 0, 0);
    chk("st_done", v8, 0);
    chk("st_pend", pend8, 0);
    cyc(8'h00, 1, 0, 0);
    chk("st_norep", v8, 0);

    // handshake on 3 in the same cycle as a new edge on 3
    cyc(8'h08, 0, 0, 0);
    cyc(8'h00, 0, 0, 0);
    cyc(8'h08, 1, 0, 0);
    chk("c3_idx", idx8, 3);
    cyc(8'h00, 0, 0, 0);
    chk("c3_pend", pend8[3], 1);
    chk("c3_nolost", lost8, 0);
    cyc(8'h00, 1, 0, 0);
    chk("c3_again_v", v8, 1);
    chk("c3_again", idx8, 3);
    cyc(8'h00, 1, 0, 0);
    chk("c3_end", v8, 0);

    // N=5: channel 4 held high through reset release
    do_reset(8'h00, 5'h10);
    cyc(8'h00, 1, 5'h10, 1);
    chk("n5_pend", pend5, 5'h10);
    cyc(8'h00, 1, 5'h10, 1);
    chk("n5_v", v5, 1);
    chk("n5_idx", idx5, 4);
    cyc(8'h00, 1, 5'h00, 1);
    chk("n5_end", v5, 0);

    // random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r8;
      logic [4:0] r5;
      r8 = 8'($urandom & $urandom);
      r5 = 5'($urandom & $urandom);
      if (i == 200) do_reset(r8, r5);
      else cyc(r8, $urandom_range(0, 3) != 0, r5, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 20; i++) cyc(8'h00, 1, 5'h00, 1);
    @(negedge clk);
    #1;
    chk("sb8_drain", q8.size(), 0);
    chk("sb5_drain", q5.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
